hd44780_led_array: RTL and testbench
====================================

Name: hd44780_led_array

Overview:
- Parametrised N-channel indicator-LED driver, replacing the ad hoc alive-blinky, PWM-dim and LED glue logic in the top level.
- Each channel has its own mode, duty and phase.
  - Modes: off, steady-dimmed, blink, one-shot.
- Per-channel output polarity is set by a parameter, so the RGB driver taps and the external active-low LEDs share one block.
- Sits beside the syscon on the wishbone clock/reset and is driven by a simple channel-write strobe from the controller or the top level.

Parameters:
- NUM_LEDS, 4, number of channels (1..16).
- CHAN_BITS, 2, width of the channel index; must satisfy 2^CHAN_BITS >= NUM_LEDS.
- PWM_BITS, 3, width of the dimming counter and the duty field.
- BLINK_BITS, `H4_TIMER_BITS+2, width of the shared blink counter; blink period is 2^BLINK_BITS clocks.
- ACTIVE_LOW, {NUM_LEDS{1'b0}}, per-channel polarity mask; 1 = output low when lit.

Ports:
- CLK_I  in  1  system clock.
- RST_I  in  1  synchronous, active-high reset.
- wr_stb  in  1  one-cycle channel-write strobe.
- wr_chan  in  CHAN_BITS  target channel.
- wr_mode  in  2  0=off, 1=steady, 2=blink, 3=one-shot.
- wr_duty  in  PWM_BITS  brightness.
- wr_phase  in  1  inverts the blink phase for this channel.
- wr_ack  out  1  write accepted; pulses the cycle after wr_stb.
- wr_err  out  1  write rejected (wr_chan >= NUM_LEDS); pulses the cycle after wr_stb.
- led_o  out  NUM_LEDS  pin-level LED drive, polarity already applied.
- frame_stb  out  1  one-cycle pulse when the blink counter wraps; used as the logic-analyzer sync strobe.

Behaviour:
- Reset (RST_I high at a clock edge):
  - All modes = 0, duties = 0, phases = 0.
  - pwm_ctr = 0, blink_ctr = 0.
  - wr_ack = 0, wr_err = 0, frame_stb = 0.
  - led_o = ACTIVE_LOW, i.e. every channel at its unlit level.
  - Reset mid one-shot cancels the shot.
- Counters:
  - pwm_ctr (PWM_BITS) and blink_ctr (BLINK_BITS) both increment every clock and wrap modulo their width.
  - frame_stb = 1 for exactly the cycle after blink_ctr rolls from all-ones to 0.
- Dimming:
  - pwm_on = 1 when duty == all-ones; otherwise pwm_on = (pwm_ctr < duty).
  - duty = 0 therefore gives a dark channel in every mode.
- Blink phase:
  - blink_ph = blink_ctr[BLINK_BITS-1] ^ phase.
- lit, per mode:
  - mode 0: lit = 0.
  - mode 1: lit = pwm_on.
  - mode 2: lit = pwm_on & blink_ph.
  - mode 3: lit = pwm_on & (shot_ctr != 0).
- Output:
  - led_o[i] is registered as lit[i] ^ ACTIVE_LOW[i].
  - Latency is 1 clock from the counter/config state to the pin.
- Write handling:
  - On wr_stb with wr_chan < NUM_LEDS, mode/duty/phase load at that edge and affect led_o from the second edge after the strobe.
  - The same write pulses wr_ack for one cycle.
  - On wr_stb with wr_chan >= NUM_LEDS, no state changes and wr_err pulses for one cycle.
- One-shot:
  - A mode-3 write loads shot_ctr (BLINK_BITS-1 bits) with all-ones.
  - shot_ctr decrements every clock while nonzero.
  - When it reaches 0, the channel mode reverts to 0 on that same edge.
  - A mode-3 rewrite during a shot reloads the counter (retrigger).
  - Writing any other mode during a shot cancels it.
- Simultaneous events:
  - A write in the same cycle as a one-shot expiry on the same channel wins: the new mode is kept.
  - A write in the same cycle as a frame_stb is unaffected by it.

Optional Feature:
- Macro: H4_LED_BREATHE_EN.
- Defined: mode 2 becomes breathe instead of square blink.
  - The effective duty is a triangle taken from the top PWM_BITS+1 bits of blink_ctr.
    - Rising phase: duty = upper bits.
    - Falling phase: duty = ~upper bits.
  - That triangle value is then ANDed bitwise with the stored duty as a brightness cap.
  - phase still inverts the triangle.
- Undefined: mode 2 is the square blink above, and no breathe logic is synthesised.

Decomposition:
- Package hd44780_led_pkg:
  - mode encodings H4L_MODE_OFF/STEADY/BLINK/ONESHOT.
  - default ACTIVE_LOW masks for the up5k RGB channels (active high) and the external LEDs (active low).
- Sub-module hd44780_led_chan: one channel's config registers, shot counter and lit logic, generated NUM_LEDS times.
- The shared counters and the write decode live in the parent.

Test Plan (NUM_LEDS=4, PWM_BITS=3, BLINK_BITS=6, ACTIVE_LOW=4'b1100):
- Reset for 2 clocks -> led_o=4'b1100, wr_ack=0, frame_stb=0; the first frame_stb arrives 64 clocks after reset release, then every 64.
- Write ch0 mode1 duty=3 -> wr_ack pulses 1 cycle later; led_o[0] is high for 3 of every 8 clocks. Duty=7 -> high continuously.
- Write ch2 mode2 duty=7 phase=0 -> led_o[2] is low (lit) while blink_ctr[5]=1 and high otherwise. Same with phase=1 -> the complement.
- Write ch1 mode3 duty=7 -> led_o[1] is high for 31 clocks, then low; the channel mode reads back 0. A retrigger at clock 20 extends the shot to 20+31.
- Write wr_chan=5 (note: CHAN_BITS must be 3 for this case) -> wr_err pulses and all outputs are unchanged. Assert RST_I mid one-shot -> led_o=4'b1100 on the next edge.

Source files
------------

// File: rtl/hd44780_led_pkg.sv
// hd44780_led_pkg
// Shared definitions for the indicator-LED driver: channel mode encodings
// and the default polarity masks for the board's LED groups.
// Optional feature macro used by the block: H4_LED_BREATHE_EN.
package hd44780_led_pkg;

    typedef enum logic [1:0] {
        H4L_MODE_OFF     = 2'd0,
        H4L_MODE_STEADY  = 2'd1,
        H4L_MODE_BLINK   = 2'd2,
        H4L_MODE_ONESHOT = 2'd3
    } h4l_mode_e;

    // up5k RGB driver taps are active high; the external LEDs sink current.
    localparam logic [2:0] H4L_ACTIVE_LOW_RGB = 3'b000;
    localparam logic [3:0] H4L_ACTIVE_LOW_EXT = 4'b1111;

endpackage

// File: rtl/hd44780_led_chan.sv
// hd44780_led_chan
// One LED channel: mode/duty/phase registers, one-shot counter and the
// combinational "lit" decision. The pin register and polarity live in the
// parent.
// Optional feature: H4_LED_BREATHE_EN turns blink mode into a triangle
// breathe capped by the stored duty.
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   wr_en_i               write strobe already decoded for this channel
//   wr_mode_i/duty_i/phase_i  config loaded on wr_en_i
//   pwm_ctr_i             shared dimming counter
//   blink_top_i           (breathe) top PWM_BITS+1 bits of the blink counter
//   blink_msb_i           (square blink) blink counter MSB
//   lit_o                 channel is lit this cycle (before polarity)
module hd44780_led_chan
    import hd44780_led_pkg::*;
#(
    parameter int PWM_BITS   = 3,
    parameter int BLINK_BITS = 6
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                wr_en_i,
    input  logic [1:0]          wr_mode_i,
    input  logic [PWM_BITS-1:0] wr_duty_i,
    input  logic                wr_phase_i,
    input  logic [PWM_BITS-1:0] pwm_ctr_i,
`ifdef H4_LED_BREATHE_EN
    input  logic [PWM_BITS:0]   blink_top_i,
`else
    input  logic                blink_msb_i,
`endif
    output logic                lit_o
);

    localparam int SHOT_W = BLINK_BITS - 1;
    localparam logic [SHOT_W-1:0] SHOT_ONE = SHOT_W'(1);

    h4l_mode_e           mode_q,  mode_d;
    logic [PWM_BITS-1:0] duty_q,  duty_d;
    logic                phase_q, phase_d;
    logic [SHOT_W-1:0]   shot_q,  shot_d;

    logic [PWM_BITS-1:0] eff_duty;
    logic                pwm_on;
    logic                blink_ph;

    // A write has priority over the shot countdown, so a write landing on
    // the expiry edge keeps its new mode.
    always_comb begin
        mode_d  = mode_q;
        duty_d  = duty_q;
        phase_d = phase_q;
        shot_d  = shot_q;
        if (wr_en_i) begin
            mode_d  = h4l_mode_e'(wr_mode_i);
            duty_d  = wr_duty_i;
            phase_d = wr_phase_i;
            shot_d  = (h4l_mode_e'(wr_mode_i) == H4L_MODE_ONESHOT) ? '1 : '0;
        end else if (shot_q != '0) begin
            shot_d = shot_q - SHOT_ONE;
            if (shot_q == SHOT_ONE) begin
                mode_d = H4L_MODE_OFF;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mode_q  <= H4L_MODE_OFF;
            duty_q  <= '0;
            phase_q <= 1'b0;
            shot_q  <= '0;
        end else begin
            mode_q  <= mode_d;
            duty_q  <= duty_d;
            phase_q <= phase_d;
            shot_q  <= shot_d;
        end
    end

`ifdef H4_LED_BREATHE_EN
    logic                tri_fall;
    logic [PWM_BITS-1:0] tri_val;

    always_comb begin
        tri_fall = blink_top_i[PWM_BITS] ^ phase_q;
        tri_val  = tri_fall ? ~blink_top_i[PWM_BITS-1:0] : blink_top_i[PWM_BITS-1:0];
        blink_ph = 1'b1;
        eff_duty = (mode_q == H4L_MODE_BLINK) ? (tri_val & duty_q) : duty_q;
    end
`else
    always_comb begin
        blink_ph = blink_msb_i ^ phase_q;
        eff_duty = duty_q;
    end
`endif

    // Full-scale duty must stay on every cycle, which the compare alone misses.
    assign pwm_on = (eff_duty == '1) || (pwm_ctr_i < eff_duty);

    always_comb begin
        lit_o = 1'b0;
        case (mode_q)
            H4L_MODE_OFF:     lit_o = 1'b0;
            H4L_MODE_STEADY:  lit_o = pwm_on;
            H4L_MODE_BLINK:   lit_o = pwm_on & blink_ph;
            H4L_MODE_ONESHOT: lit_o = pwm_on & (shot_q != '0);
            default:          lit_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/hd44780_led_array.sv
// hd44780_led_array
// N-channel indicator-LED driver: shared PWM and blink counters, write
// decode with ack/err pulses, per-channel lit logic and registered,
// polarity-corrected pin outputs.
// Optional feature: H4_LED_BREATHE_EN (blink mode becomes breathe).
// Ports:
//   CLK_I, RST_I      clock, synchronous active-high reset
//   wr_stb            one-cycle channel write strobe
//   wr_chan           target channel
//   wr_mode/duty/phase  channel configuration
//   wr_ack / wr_err   write accepted / rejected, one cycle after wr_stb
//   led_o             pin-level LED drive
//   frame_stb         pulse the cycle after the blink counter wraps
`ifndef H4_TIMER_BITS
`define H4_TIMER_BITS 4
`endif

module hd44780_led_array
    import hd44780_led_pkg::*;
#(
    parameter int                  NUM_LEDS   = 4,
    parameter int                  CHAN_BITS  = 2,
    parameter int                  PWM_BITS   = 3,
    parameter int                  BLINK_BITS = `H4_TIMER_BITS + 2,
    parameter logic [NUM_LEDS-1:0] ACTIVE_LOW = {NUM_LEDS{1'b0}}
) (
    input  logic                 CLK_I,
    input  logic                 RST_I,
    input  logic                 wr_stb,
    input  logic [CHAN_BITS-1:0] wr_chan,
    input  logic [1:0]           wr_mode,
    input  logic [PWM_BITS-1:0]  wr_duty,
    input  logic                 wr_phase,
    output logic                 wr_ack,
    output logic                 wr_err,
    output logic [NUM_LEDS-1:0]  led_o,
    output logic                 frame_stb
);

    localparam logic [CHAN_BITS:0] CHAN_LIMIT = (CHAN_BITS + 1)'(NUM_LEDS);

    logic [PWM_BITS-1:0]   pwm_ctr_q,   pwm_ctr_d;
    logic [BLINK_BITS-1:0] blink_ctr_q, blink_ctr_d;
    logic                  frame_q,     frame_d;
    logic                  ack_q,       ack_d;
    logic                  err_q,       err_d;
    logic [NUM_LEDS-1:0]   led_q,       led_d;
    logic [NUM_LEDS-1:0]   lit;
    logic                  wr_ok;

    // Widen the channel index so the range check also works when
    // 2^CHAN_BITS == NUM_LEDS.
    assign wr_ok = wr_stb && ({1'b0, wr_chan} < CHAN_LIMIT);

    for (genvar i = 0; i < NUM_LEDS; i++) begin : g_chan
        hd44780_led_chan #(
            .PWM_BITS   (PWM_BITS),
            .BLINK_BITS (BLINK_BITS)
        ) u_chan (
            .clk_i       (CLK_I),
            .rst_i       (RST_I),
            .wr_en_i     (wr_ok && (wr_chan == CHAN_BITS'(i))),
            .wr_mode_i   (wr_mode),
            .wr_duty_i   (wr_duty),
            .wr_phase_i  (wr_phase),
            .pwm_ctr_i   (pwm_ctr_q),
`ifdef H4_LED_BREATHE_EN
            .blink_top_i (blink_ctr_q[BLINK_BITS-1 -: PWM_BITS+1]),
`else
            .blink_msb_i (blink_ctr_q[BLINK_BITS-1]),
`endif
            .lit_o       (lit[i])
        );
    end

    always_comb begin
        pwm_ctr_d   = pwm_ctr_q + PWM_BITS'(1);
        blink_ctr_d = blink_ctr_q + BLINK_BITS'(1);
        frame_d     = (blink_ctr_q == '1);
        ack_d       = wr_ok;
        err_d       = wr_stb && !wr_ok;
        led_d       = lit ^ ACTIVE_LOW;
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            pwm_ctr_q   <= '0;
            blink_ctr_q <= '0;
            frame_q     <= 1'b0;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
            led_q       <= ACTIVE_LOW;
        end else begin
            pwm_ctr_q   <= pwm_ctr_d;
            blink_ctr_q <= blink_ctr_d;
            frame_q     <= frame_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
            led_q       <= led_d;
        end
    end

    assign wr_ack    = ack_q;
    assign wr_err    = err_q;
    assign led_o     = led_q;
    assign frame_stb = frame_q;

endmodule

// File: tb/tb_hd44780_led_array.sv
// Testbench for hd44780_led_array: NUM_LEDS=4, CHAN_BITS=3, PWM_BITS=3,
// BLINK_BITS=6, ACTIVE_LOW=4'b1100.
module tb_hd44780_led_array;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_stb;
    logic [2:0] wr_chan;
    logic [1:0] wr_mode;
    logic [2:0] wr_duty;
    logic       wr_phase;
    logic       wr_ack;
    logic       wr_err;
    logic [3:0] led_o;
    logic       frame_stb;

    hd44780_led_array #(
        .NUM_LEDS   (4),
        .CHAN_BITS  (3),
        .PWM_BITS   (3),
        .BLINK_BITS (6),
        .ACTIVE_LOW (4'b1100)
    ) dut (
        .CLK_I     (clk),
        .RST_I     (rst),
        .wr_stb    (wr_stb),
        .wr_chan   (wr_chan),
        .wr_mode   (wr_mode),
        .wr_duty   (wr_duty),
        .wr_phase  (wr_phase),
        .wr_ack    (wr_ack),
        .wr_err    (wr_err),
        .led_o     (led_o),
        .frame_stb (frame_stb)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference state, written from the behavioural description.
    int m_mode  [4];
    int m_duty  [4];
    int m_phase [4];
    int m_shot  [4];
    int m_pwm;
    int m_blink;
    logic [3:0] al_mask = 4'b1100;

    // {led_o[3:0], wr_ack, wr_err, frame_stb}
    logic [6:0] exp_q [$];

    logic [3:0] obs_led;
    logic       obs_ack, obs_err, obs_frm;
    int         cyc = 0;

    function automatic logic model_lit(int i);
        logic on;
        on = (m_duty[i] == 7) || (m_pwm < m_duty[i]);
        case (m_mode[i])
            1:       return on;
            2:       return on && ((m_blink >= 32) != (m_phase[i] != 0));
            3:       return on && (m_shot[i] > 0);
            default: return 1'b0;
        endcase
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic s, input logic [2:0] ch,
                        input logic [1:0] md, input logic [2:0] dt, input logic ph);
        logic [6:0] e;
        logic [6:0] got;
        rst = r; wr_stb = s; wr_chan = ch; wr_mode = md; wr_duty = dt; wr_phase = ph;
        if (r) begin
            e = {4'b1100, 3'b000};
            for (int i = 0; i < 4; i++) begin
                m_mode[i] = 0; m_duty[i] = 0; m_phase[i] = 0; m_shot[i] = 0;
            end
            m_pwm = 0; m_blink = 0;
        end else begin
            for (int i = 0; i < 4; i++) e[3+i] = model_lit(i) ^ al_mask[i];
            e[2] = s && (ch < 4);
            e[1] = s && (ch >= 4);
            e[0] = (m_blink == 63);
            for (int i = 0; i < 4; i++) begin
                if (s && (int'(ch) == i)) begin
                    m_mode[i]  = int'(md);
                    m_duty[i]  = int'(dt);
                    m_phase[i] = int'(ph);
                    m_shot[i]  = (md == 2'd3) ? 31 : 0;
                end else if (m_shot[i] > 0) begin
                    m_shot[i]--;
                    if (m_shot[i] == 0) m_mode[i] = 0;
                end
            end
            m_pwm   = (m_pwm + 1) % 8;
            m_blink = (m_blink + 1) % 64;
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        cyc++;
        obs_led = led_o; obs_ack = wr_ack; obs_err = wr_err; obs_frm = frame_stb;
        got = {led_o, wr_ack, wr_err, frame_stb};
        e = exp_q.pop_front();
        checks++;
        assert (got === e) else begin
            errors++;
            $error("FAIL cycle %0d outputs observed=%b expected=%b", cyc, got, e);
        end
        wr_stb = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 3'd0, 2'd0, 3'd0, 1'b0);
    endtask

    task automatic wr(input logic [2:0] ch, input logic [1:0] md,
                      input logic [2:0] dt, input logic ph);
        step(1'b0, 1'b1, ch, md, dt, ph);
    endtask

    int cnt;
    int pos;
    logic [3:0] prev;

    initial begin
        rst = 1'b1; wr_stb = 1'b0; wr_chan = '0; wr_mode = '0; wr_duty = '0; wr_phase = 1'b0;
        #1;
        step(1'b1, 1'b0, 3'd0, 2'd0, 3'd0, 1'b0);
        step(1'b1, 1'b0, 3'd0, 2'd0, 3'd0, 1'b0);
        check("reset_led", int'(obs_led), 12);
        check("reset_ack", int'(obs_ack), 0);
        check("reset_frame", int'(obs_frm), 0);

        // frame strobe timing
        pos = 0;
        for (int n = 1; n <= 100; n++) begin
            idle(1);
            if (obs_frm) begin pos = n; break; end
        end
        check("first_frame", pos, 64);
        pos = 0;
        for (int n = 1; n <= 100; n++) begin
            idle(1);
            if (obs_frm) begin pos = n; break; end
        end
        check("frame_period", pos, 64);

        // steady dimming on ch0
        wr(3'd0, 2'd1, 3'd3, 1'b0);
        check("ack_pulse", int'(obs_ack), 1);
        check("ack_no_err", int'(obs_err), 0);
        cnt = 0;
        for (int n = 0; n < 8; n++) begin
            idle(1);
            if (n == 0) check("ack_clear", int'(obs_ack), 0);
            cnt += int'(obs_led[0]);
        end
        check("duty3_on", cnt, 3);
        wr(3'd0, 2'd1, 3'd7, 1'b0);
        cnt = 0;
        for (int n = 0; n < 8; n++) begin idle(1); cnt += int'(obs_led[0]); end
        check("duty7_on", cnt, 8);

        // blink on ch2 (active low), both phases
        wr(3'd2, 2'd2, 3'd7, 1'b0);
        cnt = 0;
        for (int n = 0; n < 64; n++) begin idle(1); cnt += int'(!obs_led[2]); end
        check("blink_ph0_lit", cnt, 32);
        wr(3'd2, 2'd2, 3'd7, 1'b1);
        cnt = 0;
        for (int n = 0; n < 64; n++) begin idle(1); cnt += int'(!obs_led[2]); end
        check("blink_ph1_lit", cnt, 32);
        wr(3'd2, 2'd0, 3'd7, 1'b0);

        // one-shot on ch1
        wr(3'd1, 2'd3, 3'd7, 1'b0);
        cnt = 0;
        for (int n = 0; n < 200; n++) begin
            idle(1);
            if (obs_led[1]) cnt++; else if (cnt > 0) break;
        end
        check("oneshot_len", cnt, 31);
        idle(4);
        check("oneshot_off", int'(obs_led[1]), 0);

        // retrigger at clock 20
        wr(3'd1, 2'd3, 3'd7, 1'b0);
        cnt = 0;
        for (int n = 1; n <= 19; n++) begin idle(1); cnt += int'(obs_led[1]); end
        wr(3'd1, 2'd3, 3'd7, 1'b0);
        cnt += int'(obs_led[1]);
        for (int n = 0; n < 200; n++) begin
            idle(1);
            if (obs_led[1]) cnt++; else break;
        end
        check("retrigger_len", cnt, 51);

        // write landing on the expiry edge keeps the new mode
        wr(3'd1, 2'd3, 3'd7, 1'b0);
        idle(30);
        wr(3'd1, 2'd1, 3'd7, 1'b0);
        cnt = 0;
        for (int n = 0; n < 8; n++) begin idle(1); cnt += int'(obs_led[1]); end
        check("expiry_write_wins", cnt, 8);
        wr(3'd1, 2'd0, 3'd0, 1'b0);
        idle(1);

        // out-of-range channel
        prev = obs_led;
        wr(3'd5, 2'd1, 3'd7, 1'b1);
        check("err_pulse", int'(obs_err), 1);
        check("err_no_ack", int'(obs_ack), 0);
        idle(2);
        check("err_no_change", int'(obs_led), int'(prev));
        check("err_clear", int'(obs_err), 0);

        // mode change cancels a running shot
        wr(3'd1, 2'd3, 3'd7, 1'b0);
        idle(3);
        wr(3'd1, 2'd2, 3'd0, 1'b0);
        cnt = 0;
        for (int n = 0; n < 40; n++) begin idle(1); cnt += int'(obs_led[1]); end
        check("cancel_dark", cnt, 0);

        // reset during a shot
        wr(3'd1, 2'd3, 3'd7, 1'b0);
        idle(5);
        check("shot_running", int'(obs_led[1]), 1);
        step(1'b1, 1'b0, 3'd0, 2'd0, 3'd0, 1'b0);
        check("reset_mid_shot", int'(obs_led), 12);
        cnt = 0;
        for (int n = 0; n < 40; n++) begin idle(1); cnt += int'(obs_led[1]); end
        check("shot_cancelled", cnt, 0);

        // write coinciding with frame_stb
        pos = 0;
        for (int n = 0; n < 70; n++) begin
            if (m_blink == 63) begin pos = 1; break; end
            idle(1);
        end
        check("align_frame", pos, 1);
        wr(3'd3, 2'd1, 3'd7, 1'b0);
        check("frame_with_write", int'(obs_frm), 1);
        check("ack_with_frame", int'(obs_ack), 1);
        idle(1);
        check("ch3_lit_low", int'(obs_led[3]), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
